decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with register file, hazard stall, flush and halt FSM
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       inst,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   pc_plus1,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic [PC_W-1:0]   next_pc,
  output logic              ex_valid,
  output logic [15:0]       ex_inst,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_rd,
  output logic              ex_we,
  output logic [3:0]        ex_alu_ctrl,
  output logic              ex_imm_a,
  output logic              ex_imm_b,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_pixel_en,
  output logic              ex_pixel_val,
  output logic              ex_int_done,
  output logic              ex_halt,
  output logic              halted
);

  typedef enum logic [0:0] {RUN, HALT} state_t;

  typedef struct packed {
    logic              valid;
    logic [15:0]       inst;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        rd;
    logic              we;
    logic [3:0]        alu_ctrl;
    logic              imm_a;
    logic              imm_b;
    logic              branch;
    logic              jump;
    logic              memread;
    logic              memwrite;
    logic              pixel_en;
    logic              pixel_val;
    logic              int_done;
    logic              halt;
  } idex_t;

  state_t            state_q, state_d;
  idex_t             idex_q, idex_d;
  idex_t             dec;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [3:0]        op;
  logic [2:0]        rs1, rs2;
  logic              use_rs1, use_rs2;
  logic              wb_hit1, wb_hit2;
  logic              hazard;
  logic              accept;

  // Field extraction, control decode and bypassed operand read for the instruction in ID
  always_comb begin
    op      = inst[15:12];
    rs1     = inst[14] ? inst[11:9] : inst[5:3];
    rs2     = inst[8:6];
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec     = '0;

    dec.valid     = 1'b1;
    dec.inst      = inst;
    dec.pc        = pc;
    dec.rd        = inst[11:9];
    dec.we        = inst[15] | (op == 4'b0110);
    dec.imm_a     = (op == 4'b0111) | (op == 4'b1000);
    dec.imm_b     = inst[15] & inst[14];
    dec.branch    = (op == 4'b0010);
    dec.jump      = (op == 4'b0100);
    dec.memread   = (op == 4'b1000);
    dec.memwrite  = (op == 4'b0111);
    dec.pixel_en  = (op == 4'b0101);
    dec.pixel_val = inst[0];
    dec.int_done  = (op == 4'b0011);
    dec.halt      = (op == 4'b0000);

    case (op)
      4'b1100: dec.alu_ctrl = 4'b0000;
      4'b1101: dec.alu_ctrl = 4'b0001;
      4'b1110: dec.alu_ctrl = 4'b0010;
      4'b1111: dec.alu_ctrl = 4'b0011;
      4'b1011: dec.alu_ctrl = (inst[2:0] == 3'b000) ? 4'b1000 : {1'b0, inst[2:0]};
      4'b1010: dec.alu_ctrl = {1'b1, inst[2:0]};
      default: dec.alu_ctrl = 4'b1111;
    endcase

    // Which source fields the opcode really reads; only these can create a load-use hazard
    case (op)
      4'b0010, 4'b0111, 4'b1010, 4'b1011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0110, 4'b1000,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: use_rs1 = 1'b1;
      default: ;
    endcase

    wb_hit1 = wb_en && (wb_reg == rs1) && (int'(wb_reg) < NREGS);
    wb_hit2 = wb_en && (wb_reg == rs2) && (int'(wb_reg) < NREGS);

    if (wb_hit1)                 dec.a = wb_data;
    else if (int'(rs1) < NREGS)  dec.a = regs_q[rs1];
    if (wb_hit2)                 dec.b = wb_data;
    else if (int'(rs2) < NREGS)  dec.b = regs_q[rs2];
  end

  // Load-use hazard against the load currently sitting in ID/EX
  always_comb begin
    hazard = idex_q.valid && idex_q.memread && if_valid &&
             ((use_rs1 && (idex_q.rd == rs1)) || (use_rs2 && (idex_q.rd == rs2)));
  end

  // ID/EX next value and fetch stall; ex_stall wins over everything, then halt, flush, empty fetch, hazard
  always_comb begin
    idex_d   = '0;
    id_stall = 1'b0;
    accept   = 1'b0;
    if (ex_stall) begin
      idex_d   = idex_q;
      id_stall = 1'b1;
    end else if (state_q == HALT) begin
      id_stall = 1'b1;
    end else if (flush || !if_valid) begin
      id_stall = 1'b0;
    end else if (hazard) begin
      id_stall = 1'b1;
    end else begin
      idex_d = dec;
      accept = 1'b1;
    end
    if (rst) begin
      id_stall = 1'b0;
    end
    next_pc = (id_stall || (state_q == HALT) || (accept && dec.halt)) ? pc : pc_plus1;
  end

  // Halt FSM next state: a halt accepted into ID/EX locks the stage until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && dec.halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // State and ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  // Register file write port, live in every state including HALT
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (wb_en && (int'(wb_reg) == i)) begin
        regs_q[i] <= wb_data;
      end
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_inst      = idex_q.inst;
  assign ex_pc        = idex_q.pc;
  assign ex_a         = idex_q.a;
  assign ex_b         = idex_q.b;
  assign ex_rd        = idex_q.rd;
  assign ex_we        = idex_q.we;
  assign ex_alu_ctrl  = idex_q.alu_ctrl;
  assign ex_imm_a     = idex_q.imm_a;
  assign ex_imm_b     = idex_q.imm_b;
  assign ex_branch    = idex_q.branch;
  assign ex_jump      = idex_q.jump;
  assign ex_memread   = idex_q.memread;
  assign ex_memwrite  = idex_q.memwrite;
  assign ex_pixel_en  = idex_q.pixel_en;
  assign ex_pixel_val = idex_q.pixel_val;
  assign ex_int_done  = idex_q.int_done;
  assign ex_halt      = idex_q.halt;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] inst;
  logic [15:0] pc, pc_plus1;
  logic        ex_stall, flush;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic        id_stall;
  logic [15:0] next_pc;
  logic        ex_valid;
  logic [15:0] ex_inst, ex_pc;
  logic [31:0] ex_a, ex_b;
  logic [2:0]  ex_rd;
  logic        ex_we;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_imm_a, ex_imm_b, ex_branch, ex_jump, ex_memread, ex_memwrite;
  logic        ex_pixel_en, ex_pixel_val, ex_int_done, ex_halt, halted;

  int checks = 0;
  int errors = 0;
  logic [113:0] exp_q[$];
  logic last_stall = 1'b0;

  decode_stage #(.DATA_W(32), .PC_W(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .inst(inst), .pc(pc), .pc_plus1(pc_plus1),
    .ex_stall(ex_stall), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .id_stall(id_stall), .next_pc(next_pc), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_we(ex_we), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_imm_a(ex_imm_a), .ex_imm_b(ex_imm_b), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_pixel_en(ex_pixel_en),
    .ex_pixel_val(ex_pixel_val), .ex_int_done(ex_int_done), .ex_halt(ex_halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // flags: {imm_a, imm_b, branch, jump, memread, memwrite, pixel_en, pixel_val, int_done, halt}
  function automatic logic [113:0] mk(input logic [15:0] i, input logic [15:0] p,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] rd, input logic we,
                                      input logic [3:0] alu, input logic [9:0] fl);
    return {i, p, a, b, rd, we, alu, fl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [15:0] i, input logic [15:0] p);
    inst     = i;
    pc       = p;
    pc_plus1 = p + 16'd1;
    if_valid = 1'b1;
  endtask

  always @(posedge clk) last_stall <= ex_stall;

  // Monitor: every fresh ID/EX load is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && ex_valid && !last_stall) begin
      logic [113:0] got;
      logic [113:0] e;
      got = {ex_inst, ex_pc, ex_a, ex_b, ex_rd, ex_we, ex_alu_ctrl, ex_imm_a, ex_imm_b,
             ex_branch, ex_jump, ex_memread, ex_memwrite, ex_pixel_en, ex_pixel_val,
             ex_int_done, ex_halt};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ex_unexpected actual=%h required=<no issue pending>", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL ex_bundle actual=%h required=%h", got, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; inst = 16'h0000; pc = 16'h0; pc_plus1 = 16'h1;
    ex_stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_reg = 3'd0; wb_data = 32'h0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_id_stall", 64'(id_stall), 64'd0);
    chk("rst_ex_a", 64'(ex_a), 64'd0);
    tick();
    rst = 1'b0;

    // preload r3 and r4
    wb_en = 1'b1; wb_reg = 3'd3; wb_data = 32'h1234;
    tick();
    wb_reg = 3'd4; wb_data = 32'h4444;
    tick();
    wb_en = 1'b0;

    // immediate ALU reading r3
    set_inst(16'hC6C0, 16'h0010);
    exp_q.push_back(mk(16'hC6C0, 16'h0010, 32'h1234, 32'h1234, 3'd3, 1'b1, 4'b0000, 10'b0100000000));
    @(negedge clk);
    chk("run_next_pc", 64'(next_pc), 64'h0011);
    chk("run_id_stall", 64'(id_stall), 64'd0);
    tick();

    // same-cycle writeback bypass into rs2
    wb_en = 1'b1; wb_reg = 3'd2; wb_data = 32'hAA;
    set_inst(16'hB083, 16'h0012);
    exp_q.push_back(mk(16'hB083, 16'h0012, 32'h0, 32'hAA, 3'd0, 1'b1, 4'b0011, 10'b0000000100));
    tick();
    wb_en = 1'b0;

    // ALU control corner cases
    set_inst(16'hB000, 16'h0013);
    exp_q.push_back(mk(16'hB000, 16'h0013, 32'h0, 32'h0, 3'd0, 1'b1, 4'b1000, 10'b0000000000));
    tick();
    set_inst(16'hA005, 16'h0014);
    exp_q.push_back(mk(16'hA005, 16'h0014, 32'h0, 32'h0, 3'd0, 1'b1, 4'b1101, 10'b0000000100));
    tick();

    // load r4 then use r4: one stall, one bubble, then issue
    set_inst(16'h8800, 16'h0020);
    exp_q.push_back(mk(16'h8800, 16'h0020, 32'h0, 32'h0, 3'd4, 1'b1, 4'b1111, 10'b1000100000));
    tick();
    set_inst(16'hC800, 16'h0021);
    @(negedge clk);
    chk("lu_id_stall", 64'(id_stall), 64'd1);
    chk("lu_next_pc", 64'(next_pc), 64'h0021);
    tick();
    @(negedge clk);
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_stall_once", 64'(id_stall), 64'd0);
    exp_q.push_back(mk(16'hC800, 16'h0021, 32'h4444, 32'h0, 3'd4, 1'b1, 4'b0000, 10'b0100000000));
    tick();

    // flush colliding with a load-use hazard, then flush of a load
    set_inst(16'h8800, 16'h0030);
    exp_q.push_back(mk(16'h8800, 16'h0030, 32'h0, 32'h0, 3'd4, 1'b1, 4'b1111, 10'b1000100000));
    tick();
    set_inst(16'hC800, 16'h0031);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_hz_id_stall", 64'(id_stall), 64'd0);
    tick();
    set_inst(16'h8000, 16'h0032);
    @(negedge clk);
    chk("flush_hz_bubble", 64'(ex_valid), 64'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_ld_valid", 64'(ex_valid), 64'd0);
    chk("flush_ld_memread", 64'(ex_memread), 64'd0);

    // downstream stall holds ID/EX
    tick();
    set_inst(16'hA005, 16'h0050);
    exp_q.push_back(mk(16'hA005, 16'h0050, 32'h0, 32'h0, 3'd0, 1'b1, 4'b1101, 10'b0000000100));
    tick();
    ex_stall = 1'b1;
    set_inst(16'hB000, 16'h0051);
    @(negedge clk);
    chk("exstall_id_stall", 64'(id_stall), 64'd1);
    tick();
    @(negedge clk);
    chk("exstall_hold_inst", 64'(ex_inst), 64'hA005);
    chk("exstall_hold_pc", 64'(ex_pc), 64'h0050);
    tick();
    ex_stall = 1'b0;
    exp_q.push_back(mk(16'hB000, 16'h0051, 32'h0, 32'h0, 3'd0, 1'b1, 4'b1000, 10'b0000000000));
    tick();

    // halt
    set_inst(16'h0000, 16'h0040);
    exp_q.push_back(mk(16'h0000, 16'h0040, 32'h0, 32'h0, 3'd0, 1'b0, 4'b1111, 10'b0000000001));
    @(negedge clk);
    chk("halt_issue_next_pc", 64'(next_pc), 64'h0040);
    tick();
    set_inst(16'hC6C0, 16'h0041);
    @(negedge clk);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_id_stall", 64'(id_stall), 64'd1);
    chk("halt_next_pc", 64'(next_pc), 64'h0041);
    tick();
    @(negedge clk);
    chk("halt_bubble", 64'(ex_valid), 64'd0);
    tick();

    // reset out of HALT with a halt opcode presented during reset
    rst = 1'b1;
    set_inst(16'h0000, 16'h0000);
    tick(); tick();
    @(negedge clk);
    chk("rst_from_halt", 64'(halted), 64'd0);
    chk("rst_ex_valid2", 64'(ex_valid), 64'd0);
    tick();
    rst = 1'b0;
    set_inst(16'hC6C0, 16'h0060);
    exp_q.push_back(mk(16'hC6C0, 16'h0060, 32'h0, 32'h0, 3'd3, 1'b1, 4'b0000, 10'b0100000000));
    tick();
    if_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("post_rst_halted", 64'(halted), 64'd0);
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
